packet_sender_rr: RTL



---
 rtl/packet_sender_rr_pkg.sv | 24 ++
 rtl/packet_sender_rr_if.sv | 30 +++
 rtl/packet_sender_rr_arbiter.sv | 25 ++
 rtl/packet_sender_rr.sv | 112 +++++++++++
 4 files changed

// File: rtl/packet_sender_rr_pkg.sv
// Shared definitions for the round-robin packet sender: FSM states,
// slot offsets of the header fields and the SIZE-field mask.
package packet_sender_rr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRC,
        ST_DST,
        ST_SIZE,
        ST_DATA,
        ST_CRC
    } state_t;

    localparam int OFF_SRC_ID = 0;
    localparam int OFF_DST_ID = 1;
    localparam int OFF_SIZE   = 2;
    localparam int OFF_DATA   = 3;

    // Low SIZE bits carry the data-byte count; upper bits are opaque.
    function automatic int unsigned size_mask(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/packet_sender_rr_if.sv
// Buffer-side and link-side signals of the packet sender; master is the
// sender, slave is the buffers plus downstream link.
interface packet_sender_rr_if #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int NCH       = 4,
    parameter int CNT_W     = 16
);
    logic [NCH-1:0]        rempty;
    logic [NCH*UWIDTH-1:0] rdata;
    logic [NCH-1:0]        rinc;
    logic [PTR_IN_SZ-1:0]  raddr_in;
    logic [UWIDTH-1:0]     packet_out;
    logic                  packet_valid;
    logic                  packet_ready;
    logic                  sop;
    logic                  eop;
    logic [NCH-1:0]        grant;
    logic [CNT_W-1:0]      tx_count;

    modport master (
        input  rempty, rdata, packet_ready,
        output rinc, raddr_in, packet_out, packet_valid, sop, eop, grant, tx_count
    );

    modport slave (
        output rempty, rdata, packet_ready,
        input  rinc, raddr_in, packet_out, packet_valid, sop, eop, grant, tx_count
    );
endinterface

// File: rtl/packet_sender_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = PW'((int'(ptr) + k) % NCH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/packet_sender_rr.sv
// Drains whole packets from NCH slot buffers in round-robin order onto one
// byte-wide valid/ready link; the slot is popped only when CRC is accepted.
module packet_sender_rr
    import packet_sender_rr_pkg::*;
#(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int NCH       = 4,
    parameter int SIZE_BITS = 3,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    packet_sender_rr_if.master bus
);
    localparam int PW = $clog2(NCH);

    state_t                state, state_n;
    logic [PTR_IN_SZ-1:0]  raddr, raddr_n;
    logic [NCH-1:0]        grant, grant_n, arb_gnt;
    logic [PW-1:0]         ptr, ptr_n, gidx;
    logic [SIZE_BITS-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]      tx, tx_n;
    logic [UWIDTH-1:0]     cur;
    logic                  valid, accept;

    rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
        .req (~bus.rempty),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCH; i++)
            if (grant[i]) gidx = PW'(i);
    end

    assign valid  = (state != ST_IDLE);
    assign cur    = valid ? bus.rdata[gidx*UWIDTH +: UWIDTH] : '0;
    assign accept = valid & bus.packet_ready;

    always_comb begin
        state_n = state;
        raddr_n = raddr;
        grant_n = grant;
        ptr_n   = ptr;
        cnt_n   = cnt;
        tx_n    = tx;
        case (state)
            ST_IDLE: if (|arb_gnt) begin
                grant_n = arb_gnt;
                raddr_n = PTR_IN_SZ'(OFF_SRC_ID);
                state_n = ST_SRC;
            end
            ST_SRC: if (accept) begin
                raddr_n = PTR_IN_SZ'(OFF_DST_ID);
                state_n = ST_DST;
            end
            ST_DST: if (accept) begin
                raddr_n = PTR_IN_SZ'(OFF_SIZE);
                state_n = ST_SIZE;
            end
            ST_SIZE: if (accept) begin
                cnt_n   = SIZE_BITS'(cur & UWIDTH'(size_mask(SIZE_BITS)));
                raddr_n = PTR_IN_SZ'(OFF_DATA);
                state_n = (cnt_n != '0) ? ST_DATA : ST_CRC;
            end
            ST_DATA: if (accept) begin
                cnt_n   = cnt - SIZE_BITS'(1);
                raddr_n = raddr + PTR_IN_SZ'(1);
                if (cnt == SIZE_BITS'(1)) state_n = ST_CRC;
            end
            ST_CRC: if (accept) begin
                // Next search starts just past the channel that was served.
                tx_n    = tx + CNT_W'(1);
                ptr_n   = PW'((int'(gidx) + 1) % NCH);
                grant_n = '0;
                raddr_n = '0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            raddr <= '0;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
            tx    <= '0;
        end else begin
            state <= state_n;
            raddr <= raddr_n;
            grant <= grant_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            tx    <= tx_n;
        end
    end

    assign bus.packet_valid = valid;
    assign bus.packet_out   = cur;
    assign bus.sop          = (state == ST_SRC);
    assign bus.eop          = (state == ST_CRC);
    assign bus.rinc         = grant & {NCH{(state == ST_CRC) & bus.packet_ready}};
    assign bus.raddr_in     = raddr;
    assign bus.grant        = grant;
    assign bus.tx_count     = tx;
endmodule
